// File: rtl/imager_pattern_gen.sv
// rtl/imager_pattern_gen.sv - multi-lane synthetic imager with fv/lv/sync framing and test patterns
// Ports: clk, reset_n (async, active low); enable/snapshot_mode/trigger control running;
// mode and pattern_shift select the pattern; num_* and sync_* set the frame geometry;
// noise_seed reseeds the per-lane noise LFSRs; dat/fv/lv/sync/frame_start are the
// registered video outputs; busy and frame_count report status.
module imager_pattern_gen #(
    parameter int DATA_WIDTH     = 10,
    parameter int PIXELS_PER_CLK = 2,
    parameter int NUM_ROWS_WIDTH = 12,
    parameter int NUM_COLS_WIDTH = 12
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 enable,
    input  logic                                 snapshot_mode,
    input  logic                                 trigger,
    input  logic [2:0]                           mode,
    input  logic [3:0]                           pattern_shift,
    input  logic [NUM_ROWS_WIDTH-1:0]            num_active_rows,
    input  logic [NUM_ROWS_WIDTH-1:0]            num_virtual_rows,
    input  logic [NUM_COLS_WIDTH-1:0]            num_active_cols,
    input  logic [NUM_COLS_WIDTH-1:0]            num_virtual_cols,
    input  logic [NUM_ROWS_WIDTH:0]              sync_row_start,
    input  logic [NUM_ROWS_WIDTH-1:0]            sync_rows,
    input  logic [31:0]                          noise_seed,
    output logic [PIXELS_PER_CLK*DATA_WIDTH-1:0] dat,
    output logic                                 fv,
    output logic                                 lv,
    output logic                                 sync,
    output logic                                 frame_start,
    output logic                                 busy,
    output logic [15:0]                          frame_count
);
    localparam int DW  = DATA_WIDTH;
    localparam int PPC = PIXELS_PER_CLK;
    localparam int RW  = NUM_ROWS_WIDTH;
    localparam int CW  = NUM_COLS_WIDTH;

    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t state_q;

    // Configuration captured at frame boundaries
    logic [2:0]    mode_q;
    logic [3:0]    shift_q;
    logic [RW-1:0] act_rows_q, virt_rows_q, sync_rows_q;
    logic [CW-1:0] act_cols_q, virt_cols_q;
    logic [RW:0]   sync_start_q;

    logic [CW:0]          col_q;
    logic [RW:0]          row_q;
    logic [31:0]          lfsr_q [PPC];
    logic [15:0]          frame_count_q;
    logic [PPC*DW-1:0]    dat_q;
    logic                 fv_q, lv_q, sync_q, frame_start_q;

    logic [CW:0]   total_cols, hfp, lv_end;
    logic [RW:0]   total_rows;
    logic [RW+1:0] sync_end;
    logic          fv_int, lv_int, sync_low, col_last, row_last, frame_last;
    logic          run_now, start_run, latch_cfg;

    always_comb begin
        total_cols = {1'b0, act_cols_q} + {1'b0, virt_cols_q};
        total_rows = {1'b0, act_rows_q} + {1'b0, virt_rows_q};
        hfp        = {2'b00, virt_cols_q[CW-1:1]};
        lv_end     = hfp + {1'b0, act_cols_q};
        sync_end   = {1'b0, sync_start_q} + {2'b00, sync_rows_q};
        fv_int     = row_q < {1'b0, act_rows_q};
        lv_int     = fv_int && (col_q >= hfp) && (col_q < lv_end);
        sync_low   = (sync_rows_q != '0) && ({1'b0, row_q} >= {1'b0, sync_start_q})
                     && ({1'b0, row_q} < sync_end);
        col_last   = ({1'b0, col_q} + (CW+2)'(PPC)) >= {1'b0, total_cols};
        row_last   = ({1'b0, row_q} + (RW+2)'(1)) >= {1'b0, total_rows};
        frame_last = col_last && row_last;
        run_now    = (state_q == S_RUN) && enable;
        start_run  = enable && (!snapshot_mode || trigger);
        // Sample on IDLE->RUN and on every free-running wrap
        latch_cfg  = ((state_q == S_IDLE) && start_run)
                     || (run_now && frame_last && !snapshot_mode);
    end

    // Per-lane pixel generation from the counters
    logic [31:0]       px_x [PPC];
    logic [31:0]       px_y;
    logic [2:0]        bar_b [PPC];
    logic [DW-1:0]     px_v [PPC];
    logic [PPC*DW-1:0] dat_d;

    always_comb begin
        px_y  = 32'(row_q);
        dat_d = '0;
        for (int k = 0; k < PPC; k++) begin
            px_x[k]  = 32'(col_q) - 32'(hfp) + 32'(k);
            bar_b[k] = 3'(px_x[k] >> shift_q);
            px_v[k]  = '0;
            case (mode_q)
                3'd0: px_v[k] = lfsr_q[k][DW-1:0];
                3'd1: px_v[k] = DW'(px_x[k]);
                3'd2: px_v[k] = DW'(px_y);
                3'd3: px_v[k] = DW'(px_x[k] + px_y);
                3'd4: px_v[k] = DW'(frame_count_q);
                3'd5: px_v[k] = DW'(32'(frame_count_q) + px_x[k] + px_y);
                3'd6: begin
                    // Bar index repeated from the MSB down, truncated at bit 0
                    for (int i = 0; i < DW; i++) begin
                        px_v[k][DW-1-i] = bar_b[k][2 - (i % 3)];
                    end
                end
                default: px_v[k] = (px_x[k][shift_q] ^ px_y[shift_q]) ? '1 : '0;
            endcase
            dat_d[k*DW +: DW] = lv_int ? px_v[k] : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q       <= '0;
            shift_q      <= '0;
            act_rows_q   <= '0;
            virt_rows_q  <= '0;
            act_cols_q   <= '0;
            virt_cols_q  <= '0;
            sync_start_q <= '0;
            sync_rows_q  <= '0;
        end else if (latch_cfg) begin
            mode_q       <= mode;
            shift_q      <= pattern_shift;
            act_rows_q   <= num_active_rows;
            virt_rows_q  <= num_virtual_rows;
            act_cols_q   <= num_active_cols;
            virt_cols_q  <= num_virtual_cols;
            sync_start_q <= sync_row_start;
            sync_rows_q  <= sync_rows;
        end
    end

    // Noise LFSRs: step on active pixels, reseed outside the active frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < PPC; k++) lfsr_q[k] <= 32'(k + 1);
        end else begin
            for (int k = 0; k < PPC; k++) begin
                if (run_now && lv_int) begin
                    lfsr_q[k] <= {lfsr_q[k][30:0],
                                  ~(lfsr_q[k][31] ^ lfsr_q[k][21] ^ lfsr_q[k][1] ^ lfsr_q[k][0])};
                end else if ((!run_now || !fv_int) && (noise_seed != '0)) begin
                    lfsr_q[k] <= noise_seed ^ 32'(k);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            col_q         <= '0;
            row_q         <= '0;
            frame_count_q <= '0;
            dat_q         <= '0;
            fv_q          <= 1'b0;
            lv_q          <= 1'b0;
            sync_q        <= 1'b1;
            frame_start_q <= 1'b0;
        end else if (!run_now) begin
            col_q         <= '0;
            row_q         <= '0;
            dat_q         <= '0;
            fv_q          <= 1'b0;
            lv_q          <= 1'b0;
            sync_q        <= 1'b1;
            frame_start_q <= 1'b0;
            state_q       <= (state_q == S_IDLE && start_run) ? S_RUN : S_IDLE;
        end else begin
            dat_q         <= dat_d;
            fv_q          <= fv_int;
            lv_q          <= lv_int;
            sync_q        <= !sync_low;
            frame_start_q <= fv_int && (col_q == '0) && (row_q == '0);
            if (col_last) begin
                col_q <= '0;
                if (row_last) begin
                    row_q         <= '0;
                    frame_count_q <= frame_count_q + 16'd1;
                    if (snapshot_mode) state_q <= S_IDLE;
                end else begin
                    row_q <= row_q + (RW+1)'(1);
                end
            end else begin
                col_q <= col_q + (CW+1)'(PPC);
            end
        end
    end

    assign dat         = dat_q;
    assign fv          = fv_q;
    assign lv          = lv_q;
    assign sync        = sync_q;
    assign frame_start = frame_start_q;
    assign busy        = (state_q == S_RUN);
    assign frame_count = frame_count_q;
endmodule

// File: tb/tb_imager_pattern_gen.sv
// tb/tb_imager_pattern_gen.sv - self-checking bench for imager_pattern_gen
module tb_imager_pattern_gen;
    localparam int DW  = 10;
    localparam int PPC = 2;
    localparam int RW  = 12;
    localparam int CW  = 12;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic snapshot_mode = 1'b0;
    logic trigger = 1'b0;
    logic [2:0] mode = '0;
    logic [3:0] pattern_shift = '0;
    logic [RW-1:0] num_active_rows = '0;
    logic [RW-1:0] num_virtual_rows = '0;
    logic [CW-1:0] num_active_cols = '0;
    logic [CW-1:0] num_virtual_cols = '0;
    logic [RW:0] sync_row_start = '0;
    logic [RW-1:0] sync_rows = '0;
    logic [31:0] noise_seed = '0;
    logic [PPC*DW-1:0] dat;
    logic fv, lv, sync, frame_start, busy;
    logic [15:0] frame_count;

    imager_pattern_gen #(
        .DATA_WIDTH(DW), .PIXELS_PER_CLK(PPC), .NUM_ROWS_WIDTH(RW), .NUM_COLS_WIDTH(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .snapshot_mode(snapshot_mode),
        .trigger(trigger), .mode(mode), .pattern_shift(pattern_shift),
        .num_active_rows(num_active_rows), .num_virtual_rows(num_virtual_rows),
        .num_active_cols(num_active_cols), .num_virtual_cols(num_virtual_cols),
        .sync_row_start(sync_row_start), .sync_rows(sync_rows), .noise_seed(noise_seed),
        .dat(dat), .fv(fv), .lv(lv), .sync(sync), .frame_start(frame_start),
        .busy(busy), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: frame position as a flat cycle index within the frame
    int m_run = 0;
    int m_t = 0;
    int m_fc = 0;
    int c_mode, c_shift, c_ar, c_vr, c_ac, c_vc, c_srs, c_sr;
    logic [31:0] m_lfsr [PPC];
    logic [PPC*DW-1:0] e_dat;
    logic e_fv, e_lv, e_sync, e_fs, e_busy;
    int cnt_lv = 0;
    int cnt_sl = 0;
    int cap_sel = 0;
    logic [PPC*DW-1:0] qa[$];
    logic [PPC*DW-1:0] qb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int md, input int sh, input int x, input int y,
                                          input int fc, input logic [31:0] l);
        int b, rep;
        case (md)
            0: return l[DW-1:0];
            1: return DW'(x);
            2: return DW'(y);
            3: return DW'(x + y);
            4: return DW'(fc);
            5: return DW'(fc + x + y);
            6: begin
                b = (x >> sh) & 7;
                rep = 0;
                for (int j = 0; j < (DW + 2) / 3; j++) rep = (rep << 3) | b;
                return DW'(rep >> ((DW + 2) / 3 * 3 - DW));
            end
            default: return ((((x >> sh) ^ (y >> sh)) & 1) != 0) ? {DW{1'b1}} : {DW{1'b0}};
        endcase
    endfunction

    task automatic latch_model();
        c_mode = int'(mode); c_shift = int'(pattern_shift);
        c_ar = int'(num_active_rows); c_vr = int'(num_virtual_rows);
        c_ac = int'(num_active_cols); c_vc = int'(num_virtual_cols);
        c_srs = int'(sync_row_start); c_sr = int'(sync_rows);
    endtask

    task automatic reseed_model();
        for (int k = 0; k < PPC; k++) m_lfsr[k] = noise_seed ^ 32'(k);
    endtask

    // One clock: predict outputs from the model, advance, then compare after the edge
    task automatic step();
        int cpr, row, col, hfp;
        bit fvi, lvi, slow, seeded;
        logic nb;
        seeded = (noise_seed != 0);
        e_dat = '0; e_fv = 0; e_lv = 0; e_sync = 1; e_fs = 0;
        if (!enable) begin
            m_run = 0; m_t = 0;
            if (seeded) reseed_model();
        end else if (m_run == 0) begin
            if (seeded) reseed_model();
            if (!snapshot_mode || trigger) begin
                latch_model(); m_run = 1; m_t = 0;
            end
        end else begin
            cpr = (c_ac + c_vc) / PPC;
            row = m_t / cpr;
            col = (m_t % cpr) * PPC;
            hfp = c_vc / 2;
            fvi = row < c_ar;
            lvi = fvi && col >= hfp && col < hfp + c_ac;
            slow = (c_sr != 0) && row >= c_srs && row < c_srs + c_sr;
            e_fv = fvi; e_lv = lvi; e_sync = !slow; e_fs = fvi && (m_t == 0);
            if (lvi)
                for (int k = 0; k < PPC; k++)
                    e_dat[k*DW +: DW] = pix(c_mode, c_shift, col - hfp + k, row, m_fc, m_lfsr[k]);
            for (int k = 0; k < PPC; k++) begin
                if (lvi) begin
                    nb = ~(m_lfsr[k][31] ^ m_lfsr[k][21] ^ m_lfsr[k][1] ^ m_lfsr[k][0]);
                    m_lfsr[k] = {m_lfsr[k][30:0], nb};
                end else if (!fvi && seeded) begin
                    m_lfsr[k] = noise_seed ^ 32'(k);
                end
            end
            m_t++;
            if (m_t == cpr * (c_ar + c_vr)) begin
                m_t = 0;
                m_fc = (m_fc + 1) % 65536;
                if (snapshot_mode) m_run = 0;
                else latch_model();
            end
        end
        e_busy = (m_run != 0);
        @(posedge clk);
        #1;
        chk("dat", 32'(dat), 32'(e_dat));
        chk("fv", 32'(fv), 32'(e_fv));
        chk("lv", 32'(lv), 32'(e_lv));
        chk("sync", 32'(sync), 32'(e_sync));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("frame_count", 32'(frame_count), 32'(m_fc));
        if (lv) cnt_lv++;
        if (!sync) cnt_sl++;
        if (cap_sel == 1) qa.push_back(dat);
        if (cap_sel == 2) qb.push_back(dat);
    endtask

    task automatic cfg(input int md, input int sh, input int ar, input int vr, input int ac,
                       input int vc, input int srs, input int sr);
        mode = 3'(md); pattern_shift = 4'(sh);
        num_active_rows = RW'(ar); num_virtual_rows = RW'(vr);
        num_active_cols = CW'(ac); num_virtual_cols = CW'(vc);
        sync_row_start = (RW+1)'(srs); sync_rows = RW'(sr);
    endtask

    function automatic int stream_diff();
        int n = 0;
        for (int i = 0; i < qa.size(); i++) if (qa[i] !== qb[i]) n++;
        return n;
    endfunction

    initial begin
        int fc_hold, flen;
        for (int k = 0; k < PPC; k++) m_lfsr[k] = 32'(k + 1);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dat", 32'(dat), 0);
        chk("rst_fv", 32'(fv), 0);
        chk("rst_lv", 32'(lv), 0);
        chk("rst_sync", 32'(sync), 1);
        chk("rst_frame_start", 32'(frame_start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_count", 32'(frame_count), 0);
        reset_n = 1'b1;
        step();

        // 4x4 column gradient, two free-running frames
        cfg(1, 0, 4, 2, 4, 4, 7, 0);
        enable = 1'b1;
        cnt_lv = 0;
        repeat (49) step();
        chk("grad_lv_cycles", 32'(cnt_lv), 16);
        chk("grad_frames", 32'(frame_count), 2);

        // Snapshot: one frame per trigger, mid-frame and final-cycle triggers ignored
        enable = 1'b0; step();
        snapshot_mode = 1'b1; enable = 1'b1;
        repeat (3) step();
        trigger = 1'b1; step(); trigger = 1'b0;
        repeat (10) step();
        trigger = 1'b1; step(); trigger = 1'b0;
        repeat (20) step();
        chk("snap_fc", 32'(frame_count), 3);
        chk("snap_busy", 32'(busy), 0);
        trigger = 1'b1; step(); trigger = 1'b0;
        repeat (23) step();
        trigger = 1'b1; step(); trigger = 1'b0;
        repeat (5) step();
        chk("snap_last_trig_fc", 32'(frame_count), 4);
        chk("snap_last_trig_busy", 32'(busy), 0);
        snapshot_mode = 1'b0;

        // Checkerboard, shift 1, 8x8
        enable = 1'b0; step();
        cfg(7, 1, 8, 2, 8, 4, 20, 0);
        enable = 1'b1;
        repeat (61) step();

        // Width change mid-frame only takes effect next frame
        enable = 1'b0; step();
        cfg(1, 0, 4, 2, 4, 4, 20, 0);
        enable = 1'b1;
        repeat (10) step();
        num_active_cols = CW'(8);
        repeat (60) step();

        // Seeded noise repeats frame to frame; unseeded does not
        enable = 1'b0; step();
        cfg(0, 0, 4, 2, 4, 4, 20, 0);
        noise_seed = 32'h1234;
        enable = 1'b1;
        repeat (30) step();
        qa.delete(); qb.delete();
        cap_sel = 1; repeat (24) step();
        cap_sel = 2; repeat (24) step();
        cap_sel = 0;
        chk("seeded_repeat", 32'(stream_diff()), 0);
        noise_seed = 32'h0;
        repeat (30) step();
        qa.delete(); qb.delete();
        cap_sel = 1; repeat (24) step();
        cap_sel = 2; repeat (24) step();
        cap_sel = 0;
        chk("free_noise_differs", 32'(stream_diff() != 0), 1);

        // Sync low on rows 2..4, then abort mid-frame
        enable = 1'b0; step();
        cfg(2, 0, 4, 2, 4, 4, 2, 3);
        enable = 1'b1;
        cnt_sl = 0;
        repeat (25) step();
        chk("sync_low_cycles", 32'(cnt_sl), 12);
        repeat (9) step();
        fc_hold = m_fc;
        enable = 1'b0; step();
        chk("abort_dat", 32'(dat), 0);
        chk("abort_sync", 32'(sync), 1);
        chk("abort_fc", 32'(frame_count), 32'(fc_hold));
        repeat (3) step();

        // Zero active rows: no fv, frames still counted
        cfg(1, 0, 0, 3, 4, 4, 0, 0);
        enable = 1'b1;
        fc_hold = m_fc;
        repeat (25) step();
        chk("zero_rows_fc", 32'(frame_count), 32'((fc_hold + 2) % 65536));

        // Randomized configurations, triggers and mid-frame input changes
        for (int it = 0; it < 10; it++) begin
            enable = 1'b0; step();
            cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 6)), int'($urandom_range(1, 3)),
                PPC * int'($urandom_range(0, 5)), 2 * PPC * int'($urandom_range(1, 3)),
                int'($urandom_range(0, 10)), int'($urandom_range(0, 4)));
            noise_seed = ($urandom_range(0, 1) == 1) ? $urandom : 32'h0;
            snapshot_mode = 1'($urandom_range(0, 1));
            enable = 1'b1;
            flen = (int'(num_active_cols) + int'(num_virtual_cols)) / PPC
                   * (int'(num_active_rows) + int'(num_virtual_rows));
            for (int c = 0; c < 2 * flen + 6; c++) begin
                trigger = ($urandom_range(0, 7) == 0);
                if (c == flen / 2) mode = 3'($urandom_range(0, 7));
                step();
            end
            trigger = 1'b0;
        end
        snapshot_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
